// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
//
// Bundle of the request/response handshake and data signals of the
// multi-cycle execute-stage ALU (alu_mc).
//
// Parameters
//   DATA_W    operand/result width
//   ALU_OP_W  one-hot operation vector width
//
// Signals
//   in_valid, in_ready          request handshake (accept on in_valid & in_ready)
//   alu_op                      one-hot operation select
//   alu_src1, alu_src2          operands (rj, rk/imm)
//   src_is_signed               signed mulh/div/mod when 1
//   out_valid, out_ready        response handshake
//   alu_result                  registered result
//   div_unsupported             div/mod issued without a divider, qualified by out_valid
//
// Modports
//   master  the issuing side (decode stage / testbench)
//   slave   the ALU
// -----------------------------------------------------------------------------
interface alu_mc_if #(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_src1;
    logic [DATA_W-1:0]   alu_src2;
    logic                src_is_signed;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   alu_result;
    logic                div_unsupported;

    modport master (
        output in_valid,
        output alu_op,
        output alu_src1,
        output alu_src2,
        output src_is_signed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  alu_result,
        input  div_unsupported
    );

    modport slave (
        input  in_valid,
        input  alu_op,
        input  alu_src1,
        input  alu_src2,
        input  src_is_signed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output alu_result,
        output div_unsupported
    );
endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
//
// Multi-cycle, parametrised execute-stage ALU. One operation is accepted at a
// time through a valid/ready handshake:
//   - logic / add / shift / compare / lui complete in one cycle
//   - mul / mulh take two cycles
//   - div / mod run through a radix-2 restoring divider (DATA_W iterations
//     plus one sign-fix cycle); divide-by-zero and signed MIN / -1 finish in
//     one cycle without entering the divider
//
// Compile-time option
//   ALU_DIV_EN  when defined the iterative divider is built and
//               div_unsupported is tied low. When undefined no divider logic
//               exists; div/mod complete in one cycle with result 0 and
//               div_unsupported set.
//
// Ports
//   clk    clock
//   reset  synchronous, active-high reset
//   flush  synchronous kill of any in-flight or held operation
//   bus    alu_mc_if.slave handshake / operand / result bundle
//
// alu_op bit map (lowest set bit wins, zero-hot returns 0):
//   0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//   8 sll, 9 srl, 10 sra, 11 lui, 12 mul, 13 mulh, 14 div, 15 mod
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 16,
    parameter int SHAMT_W  = $clog2(DATA_W)
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    alu_mc_if.slave bus
);

    localparam int MSB     = DATA_W - 1;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;
    localparam int OP_MUL  = 12;
    localparam int OP_MULH = 13;
    localparam int OP_DIV  = 14;
    localparam int OP_MOD  = 15;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t              state;
    logic                out_valid_q;
    logic [DATA_W-1:0]   alu_result_q;

    logic [DATA_W-1:0]   mul_a;
    logic [DATA_W-1:0]   mul_b;
    logic                mul_signed;
    logic                mul_high;

    logic                accept;
    logic [ALU_OP_W-1:0] op_sel;
    logic                is_mul;
    logic                is_div;

    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [SHAMT_W-1:0]  shamt;
    logic signed [DATA_W-1:0] src1_s;

    logic [DATA_W:0]     sub_full;
    logic [DATA_W-1:0]   sub_res;
    logic                sub_borrow;
    logic                sub_ovf;
    logic                slt_bit;
    logic [DATA_W-1:0]   single_res;

    logic signed [2*DATA_W-1:0] mul_ext_a;
    logic signed [2*DATA_W-1:0] mul_ext_b;
    logic signed [2*DATA_W-1:0] mul_prod;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return (~v) + DATA_W'(1);
    endfunction

    assign src1   = bus.alu_src1;
    assign src2   = bus.alu_src2;
    assign src1_s = bus.alu_src1;
    assign shamt  = src2[SHAMT_W-1:0];

    // Acceptance is possible from IDLE, or from DONE in the same cycle the
    // held result is consumed, so single-cycle ops can stream one per cycle.
    assign bus.in_ready = ((state == IDLE) | ((state == DONE) & bus.out_ready))
                          & ~flush & ~reset;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = alu_result_q;

    // Isolate the lowest set bit so multi-hot vectors resolve by priority and
    // zero-hot yields an all-zero select (result 0, single-cycle class).
    assign op_sel = bus.alu_op & ((~bus.alu_op) + ALU_OP_W'(1));
    assign is_mul = op_sel[OP_MUL] | op_sel[OP_MULH];
    assign is_div = op_sel[OP_DIV] | op_sel[OP_MOD];

    // sub, slt and sltu share one src1 + ~src2 + 1 adder; the missing carry
    // out is the unsigned borrow, and the signed compare corrects the sign
    // bit by the two's-complement overflow.
    assign sub_full   = {1'b0, src1} + {1'b0, ~src2} + {{DATA_W{1'b0}}, 1'b1};
    assign sub_res    = sub_full[DATA_W-1:0];
    assign sub_borrow = ~sub_full[DATA_W];
    assign sub_ovf    = (src1[MSB] ^ src2[MSB]) & (sub_res[MSB] ^ src1[MSB]);
    assign slt_bit    = sub_res[MSB] ^ sub_ovf;

    // Result of every single-cycle operation, captured at acceptance.
    always_comb begin
        single_res = '0;
        if (op_sel[OP_ADD])       single_res = src1 + src2;
        else if (op_sel[OP_SUB])  single_res = sub_res;
        else if (op_sel[OP_SLT])  single_res = {{(DATA_W-1){1'b0}}, slt_bit};
        else if (op_sel[OP_SLTU]) single_res = {{(DATA_W-1){1'b0}}, sub_borrow};
        else if (op_sel[OP_AND])  single_res = src1 & src2;
        else if (op_sel[OP_NOR])  single_res = ~(src1 | src2);
        else if (op_sel[OP_OR])   single_res = src1 | src2;
        else if (op_sel[OP_XOR])  single_res = src1 ^ src2;
        else if (op_sel[OP_SLL])  single_res = src1 << shamt;
        else if (op_sel[OP_SRL])  single_res = src1 >> shamt;
        else if (op_sel[OP_SRA])  single_res = src1_s >>> shamt;
        else if (op_sel[OP_LUI])  single_res = src2;
    end

    // The (DATA_W+1)-bit extended product only matters in its low 2*DATA_W
    // bits, so extending both operands to 2*DATA_W and multiplying modulo
    // 2^(2*DATA_W) gives the same low and high halves.
    assign mul_ext_a = {{DATA_W{mul_signed & mul_a[MSB]}}, mul_a};
    assign mul_ext_b = {{DATA_W{mul_signed & mul_b[MSB]}}, mul_b};
    assign mul_prod  = mul_ext_a * mul_ext_b;

`ifdef ALU_DIV_EN
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_dsr;
    logic [CNT_W-1:0]  div_cnt;
    logic              div_neg_q;
    logic              div_neg_r;
    logic              div_is_mod;

    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;
    logic              div_by_zero;
    logic              div_ovf;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;

    assign abs1        = (bus.src_is_signed & src1[MSB]) ? negate(src1) : src1;
    assign abs2        = (bus.src_is_signed & src2[MSB]) ? negate(src2) : src2;
    assign div_by_zero = (src2 == '0);
    assign div_ovf     = bus.src_is_signed & (src1 == {1'b1, {(DATA_W-1){1'b0}}})
                         & (&src2);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow. The
    // partial remainder stays below the divisor, so bit DATA_W of the trial
    // difference is a reliable sign.
    assign div_shift = {div_rem, div_quo[MSB]};
    assign div_trial = div_shift - {1'b0, div_dsr};

    assign bus.div_unsupported = 1'b0;
`else
    logic div_unsup_q;

    assign bus.div_unsupported = div_unsup_q;
`endif

    // Control FSM and all datapath registers. Reset beats flush, flush beats
    // the normal handshake; flush drops whatever is in MUL, DIV or DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_signed   <= 1'b0;
            mul_high     <= 1'b0;
`ifdef ALU_DIV_EN
            div_quo      <= '0;
            div_rem      <= '0;
            div_dsr      <= '0;
            div_cnt      <= '0;
            div_neg_q    <= 1'b0;
            div_neg_r    <= 1'b0;
            div_is_mod   <= 1'b0;
`else
            div_unsup_q  <= 1'b0;
`endif
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
            div_cnt     <= '0;
`else
            div_unsup_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                    if (accept) begin
`ifndef ALU_DIV_EN
                        div_unsup_q <= 1'b0;
`endif
                        if (is_mul) begin
                            mul_a       <= src1;
                            mul_b       <= src2;
                            mul_signed  <= bus.src_is_signed;
                            mul_high    <= op_sel[OP_MULH];
                            out_valid_q <= 1'b0;
                            state       <= MUL;
                        end else if (is_div) begin
`ifdef ALU_DIV_EN
                            if (div_by_zero) begin
                                alu_result_q <= op_sel[OP_MOD] ? src1 : '1;
                                out_valid_q  <= 1'b1;
                                state        <= DONE;
                            end else if (div_ovf) begin
                                alu_result_q <= op_sel[OP_MOD] ? '0 : src1;
                                out_valid_q  <= 1'b1;
                                state        <= DONE;
                            end else begin
                                div_quo     <= abs1;
                                div_rem     <= '0;
                                div_dsr     <= abs2;
                                div_cnt     <= '0;
                                div_neg_q   <= bus.src_is_signed & (src1[MSB] ^ src2[MSB]);
                                div_neg_r   <= bus.src_is_signed & src1[MSB];
                                div_is_mod  <= op_sel[OP_MOD];
                                out_valid_q <= 1'b0;
                                state       <= DIV;
                            end
`else
                            alu_result_q <= '0;
                            div_unsup_q  <= 1'b1;
                            out_valid_q  <= 1'b1;
                            state        <= DONE;
`endif
                        end else begin
                            alu_result_q <= single_res;
                            out_valid_q  <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end

                MUL: begin
                    alu_result_q <= mul_high ? mul_prod[2*DATA_W-1:DATA_W]
                                             : mul_prod[DATA_W-1:0];
                    out_valid_q  <= 1'b1;
                    state        <= DONE;
                end

`ifdef ALU_DIV_EN
                // After DATA_W iterations the magnitudes are final; one more
                // cycle applies the signs and publishes the result.
                DIV: begin
                    if (div_cnt == CNT_W'(DATA_W)) begin
                        if (div_is_mod) begin
                            alu_result_q <= div_neg_r ? negate(div_rem) : div_rem;
                        end else begin
                            alu_result_q <= div_neg_q ? negate(div_quo) : div_quo;
                        end
                        div_cnt     <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        if (!div_trial[DATA_W]) begin
                            div_rem <= div_trial[DATA_W-1:0];
                            div_quo <= {div_quo[MSB-1:0], 1'b1};
                        end else begin
                            div_rem <= div_shift[DATA_W-1:0];
                            div_quo <= {div_quo[MSB-1:0], 1'b0};
                        end
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
`endif

                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
//
// Directed, self-checking bench for alu_mc at DATA_W = 32. Expected values are
// hand-computed constants. Divider cases are selected by ALU_DIV_EN to match
// the build of the design under test.
// -----------------------------------------------------------------------------
module tb_alu_mc;

    localparam int DATA_W   = 32;
    localparam int ALU_OP_W = 16;

    localparam logic [15:0] OP_ADD  = 16'h0001;
    localparam logic [15:0] OP_SUB  = 16'h0002;
    localparam logic [15:0] OP_SLT  = 16'h0004;
    localparam logic [15:0] OP_SLTU = 16'h0008;
    localparam logic [15:0] OP_AND  = 16'h0010;
    localparam logic [15:0] OP_NOR  = 16'h0020;
    localparam logic [15:0] OP_OR   = 16'h0040;
    localparam logic [15:0] OP_XOR  = 16'h0080;
    localparam logic [15:0] OP_SLL  = 16'h0100;
    localparam logic [15:0] OP_SRL  = 16'h0200;
    localparam logic [15:0] OP_SRA  = 16'h0400;
    localparam logic [15:0] OP_LUI  = 16'h0800;
    localparam logic [15:0] OP_MUL  = 16'h1000;
    localparam logic [15:0] OP_MULH = 16'h2000;
    localparam logic [15:0] OP_DIV  = 16'h4000;
    localparam logic [15:0] OP_MOD  = 16'h8000;

    typedef struct packed {
        logic [15:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 17;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;

    vec_t vecs [NV];

    alu_mc_if #(.DATA_W(DATA_W), .ALU_OP_W(ALU_OP_W)) bus ();

    alu_mc #(.DATA_W(DATA_W), .ALU_OP_W(ALU_OP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running 10 ns clock; stimulus and sampling happen on the falling edge.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operation on the request side (does not advance time).
    task automatic applyStimulus(input logic [15:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic sgn);
        bus.alu_op        = op;
        bus.alu_src1      = a;
        bus.alu_src2      = b;
        bus.src_is_signed = sgn;
        bus.in_valid      = 1'b1;
    endtask

    // Issue one op expecting acceptance this cycle; returns at the falling
    // edge of the cycle after acceptance (N+1).
    task automatic issueOp(input string tag, input logic [15:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic sgn);
        applyStimulus(op, a, b, sgn);
        #1;
        checkOutput({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, starting at N+1, and check latency,
    // result and the unsupported flag.
    task automatic expectResult(input string tag, input int exp_lat,
                                input logic [31:0] exp_res, input logic exp_unsup);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_res"}, 64'(bus.alu_result), 64'(exp_res));
        checkOutput({tag, "_unsup"}, 64'(bus.div_unsupported), 64'(exp_unsup));
    endtask

    initial begin
        int seen;

        bus.in_valid      = 1'b0;
        bus.alu_op        = '0;
        bus.alu_src1      = '0;
        bus.alu_src2      = '0;
        bus.src_is_signed = 1'b0;
        bus.out_ready     = 1'b1;

        vecs = '{
            '{OP_SUB,          32'd5,         32'd7,         32'hFFFF_FFFE},
            '{OP_SLT,          32'hFFFF_FFFF, 32'd1,         32'd1},
            '{OP_SLTU,         32'hFFFF_FFFF, 32'd1,         32'd0},
            '{OP_SLTU,         32'd1,         32'hFFFF_FFFF, 32'd1},
            '{OP_SLT,          32'h7FFF_FFFF, 32'h8000_0000, 32'd0},
            '{OP_AND,          32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
            '{OP_NOR,          32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF},
            '{OP_OR,           32'h1200_0034, 32'h0034_5600, 32'h1234_5634},
            '{OP_XOR,          32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
            '{OP_SLL,          32'd1,         32'h0000_0021, 32'd2},
            '{OP_SRL,          32'h8000_0000, 32'd31,        32'd1},
            '{OP_LUI,          32'd0,         32'hABCD_0000, 32'hABCD_0000},
            '{16'h0000,        32'd5,         32'd7,         32'd0},
            '{OP_ADD | OP_SUB, 32'd5,         32'd7,         32'd12},
            '{OP_AND | OP_XOR, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00},
            '{OP_ADD,          32'hFFFF_FFFF, 32'd2,         32'd1},
            '{OP_SRA,          32'h7FFF_FFF0, 32'd4,         32'h07FF_FFFF}
        };

        // Reset held for three cycles: everything quiet, no acceptance.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst%0d_rdy", i), 64'(bus.in_ready), 64'd0);
            checkOutput($sformatf("rst%0d_valid", i), 64'(bus.out_valid), 64'd0);
            checkOutput($sformatf("rst%0d_res", i), 64'(bus.alu_result), 64'd0);
            checkOutput($sformatf("rst%0d_unsup", i), 64'(bus.div_unsupported), 64'd0);
        end
        reset = 1'b0;

        // First op straight out of reset: add 5+7 at N, 12 at N+1.
        issueOp("add", OP_ADD, 32'd5, 32'd7, 1'b0);
        checkOutput("add_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("add_res", 64'(bus.alu_result), 64'd12);
        @(negedge clk);
        checkOutput("add_drain", 64'(bus.out_valid), 64'd0);

        // Single-cycle ops streamed back to back with out_ready tied high.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            #1;
            checkOutput($sformatf("tp%0d_rdy", i), 64'(bus.in_ready), 64'd1);
            @(negedge clk);
            checkOutput($sformatf("tp%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("tp%0d_res", i), 64'(bus.alu_result), 64'(vecs[i].exp));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Multiply family: two-cycle latency.
        issueOp("mulh_s", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expectResult("mulh_s", 2, 32'h0000_0000, 1'b0);
        issueOp("mulh_u", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expectResult("mulh_u", 2, 32'hFFFF_FFFE, 1'b0);
        issueOp("mul_s", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expectResult("mul_s", 2, 32'h0000_0001, 1'b0);
        issueOp("mul_u", OP_MUL, 32'hFFFF_FFFE, 32'd3, 1'b0);
        expectResult("mul_u", 2, 32'hFFFF_FFFA, 1'b0);
        issueOp("mulh_neg", OP_MULH, 32'hFFFF_FFFE, 32'd3, 1'b1);
        expectResult("mulh_neg", 2, 32'hFFFF_FFFF, 1'b0);
        issueOp("mulh_big", OP_MULH, 32'h0001_0000, 32'h0001_0000, 1'b0);
        expectResult("mulh_big", 2, 32'h0000_0001, 1'b0);
        @(negedge clk);

        // Backpressure: result held while out_ready is low, new op refused.
        bus.out_ready = 1'b0;
        issueOp("sra", OP_SRA, 32'h8000_0000, 32'd4, 1'b0);
        checkOutput("sra_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("sra_res", 64'(bus.alu_result), 64'hF800_0000);
        applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("hold%0d_res", i), 64'(bus.alu_result), 64'hF800_0000);
            checkOutput($sformatf("hold%0d_rdy", i), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("release_rdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("release_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("release_res", 64'(bus.alu_result), 64'd2);
        @(negedge clk);

        // Flush while in MUL: no result, same-cycle request refused.
        issueOp("mulf", OP_MUL, 32'd3, 32'd4, 1'b0);
        flush = 1'b1;
        applyStimulus(OP_ADD, 32'd9, 32'd9, 1'b0);
        #1;
        checkOutput("mulf_flush_rdy", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("mulf_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mulf_rdy", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checkOutput("mulf_quiet", 64'(seen), 64'd0);

        // Flush while a result is held in DONE.
        bus.out_ready = 1'b0;
        issueOp("donef", OP_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        checkOutput("donef_res", 64'(bus.alu_result), 64'h0000_00FF);
        flush = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("donef_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);

`ifdef ALU_DIV_EN
        // Signed div/mod back to back: -7/2 = -3, -7%2 = -1.
        issueOp("div_s", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        expectResult("div_s", 34, 32'hFFFF_FFFD, 1'b0);
        issueOp("mod_s", OP_MOD, 32'hFFFF_FFF9, 32'd2, 1'b1);
        expectResult("mod_s", 34, 32'hFFFF_FFFF, 1'b0);
        issueOp("div_s2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
        expectResult("div_s2", 34, 32'hFFFF_FFFD, 1'b0);
        issueOp("mod_s2", OP_MOD, 32'd7, 32'hFFFF_FFFE, 1'b1);
        expectResult("mod_s2", 34, 32'd1, 1'b0);
        issueOp("div_u", OP_DIV, 32'd100, 32'd7, 1'b0);
        expectResult("div_u", 34, 32'd14, 1'b0);
        issueOp("mod_u", OP_MOD, 32'd100, 32'd7, 1'b0);
        expectResult("mod_u", 34, 32'd2, 1'b0);

        // Shortcut cases: one-cycle latency.
        issueOp("div_z", OP_DIV, 32'h0000_0010, 32'd0, 1'b0);
        expectResult("div_z", 1, 32'hFFFF_FFFF, 1'b0);
        issueOp("mod_z", OP_MOD, 32'h0000_0010, 32'd0, 1'b0);
        expectResult("mod_z", 1, 32'h0000_0010, 1'b0);
        issueOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        expectResult("div_ovf", 1, 32'h8000_0000, 1'b0);
        issueOp("mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        expectResult("mod_ovf", 1, 32'h0000_0000, 1'b0);
        @(negedge clk);

        // Flush at DIV cycle 10: the killed op never produces out_valid.
        issueOp("divf", OP_DIV, 32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 9; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("divf_rdy", 64'(bus.in_ready), 64'd1);
        checkOutput("divf_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checkOutput("divf_quiet", 64'(seen), 64'd0);

        // Divider restarts cleanly after the flush.
        issueOp("div_after", OP_DIV, 32'd1000, 32'd3, 1'b0);
        expectResult("div_after", 34, 32'd333, 1'b0);
        @(negedge clk);
`else
        // No divider built: div/mod finish at N+1 with 0 and the flag set.
        issueOp("div_nd", OP_DIV, 32'h0000_0010, 32'd3, 1'b0);
        expectResult("div_nd", 1, 32'd0, 1'b1);
        checkOutput("div_nd_valid", 64'(bus.out_valid), 64'd1);
        issueOp("mod_nd", OP_MOD, 32'hFFFF_FFF9, 32'd2, 1'b1);
        expectResult("mod_nd", 1, 32'd0, 1'b1);
        issueOp("add_nd", OP_ADD, 32'd20, 32'd22, 1'b0);
        expectResult("add_nd", 1, 32'd42, 1'b0);
        @(negedge clk);
`endif

        // Reset mid-operation discards it and returns to the reset state.
        issueOp("mulr", OP_MUL, 32'd3, 32'd4, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mulr_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mulr_res", 64'(bus.alu_result), 64'd0);
        checkOutput("mulr_rdy", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("mulr_rdy_after", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        checkOutput("mulr_quiet", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
